// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Optional build macro: IMEM_PARITY_EN (adds per-word even parity).
package imem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } imem_state_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x WIDTH storage: one synchronous write port, one synchronous read port.
// Contents are not reset; the read register holds while rd_en is low.
module imem_array #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_idx];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_loadable.sv
// Writable instruction memory: load FSM streams a program in, IF stage fetches
// with 1-cycle latency and stall hold. Optional macro: IMEM_PARITY_EN.
module imem_loadable
  import imem_pkg::*;
#(
  parameter  int DEPTH  = 64,
  parameter  int ADDR_W = 32,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [IDX_W:0]    ld_count,
  output logic              busy,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_stall,
  output logic              f_valid,
  output logic [31:0]       f_data,
  output logic              f_fault
`ifdef IMEM_PARITY_EN
  ,
  output logic              f_perr
`endif
);

`ifdef IMEM_PARITY_EN
  localparam int WORD_W = 33;
`else
  localparam int WORD_W = 32;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] PTR_INC  = IDX_W'(1'b1);
  localparam logic [IDX_W:0]   CNT_INC  = (IDX_W + 1)'(1'b1);

  imem_state_t       state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic              nop_sel_q, nop_sel_d;
  logic              chk_q, chk_d;

  logic              beat_s;
  logic              accept_s;
  logic              fault_s;
  logic [IDX_W-1:0]  idx_s;
  logic [WORD_W-1:0] wr_word_s;
  logic [WORD_W-1:0] rd_word_s;

  assign beat_s   = (state_q == LOAD) && ld_valid;
  assign accept_s = (state_q == READY) && !ld_start && f_req && !f_stall;
  assign idx_s    = f_addr[IDX_W+1:2];
  assign fault_s  = (f_addr[1:0] != 2'b00)
                 || ({1'b0, idx_s} >= count_q)
                 || ((f_addr >> (IDX_W + 2)) != {ADDR_W{1'b0}});

`ifdef IMEM_PARITY_EN
  assign wr_word_s = {even_parity(ld_data), ld_data};
  assign f_perr    = chk_q && (even_parity(rd_word_s[31:0]) != rd_word_s[32]);
`else
  assign wr_word_s = ld_data;
`endif

  imem_array #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (beat_s),
    .wr_idx  (ptr_q),
    .wr_data (wr_word_s),
    .rd_en   (accept_s),
    .rd_idx  (idx_s),
    .rd_data (rd_word_s)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (ld_start) begin
          state_d = LOAD;
          ptr_d   = {IDX_W{1'b0}};
          count_d = {(IDX_W + 1){1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      LOAD: begin
        if (beat_s) begin
          ptr_d   = ptr_q + PTR_INC;
          count_d = count_q + CNT_INC;
          // A full array ends the load even without ld_last.
          if (ld_last || (ptr_q == LAST_IDX)) begin
            state_d = READY;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = {IDX_W{1'b0}};
        count_d = {(IDX_W + 1){1'b0}};
      end
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    fault_d   = fault_q;
    nop_sel_d = nop_sel_q;
    chk_d     = chk_q;
    if ((state_q != READY) || ld_start) begin
      valid_d = 1'b0;
      fault_d = 1'b0;
      chk_d   = 1'b0;
    end else if (f_stall) begin
      valid_d = valid_q;
    end else if (f_req) begin
      valid_d   = 1'b1;
      fault_d   = fault_s;
      nop_sel_d = fault_s;
      chk_d     = !fault_s;
    end else begin
      valid_d = 1'b0;
      fault_d = 1'b0;
      chk_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= {IDX_W{1'b0}};
      count_q   <= {(IDX_W + 1){1'b0}};
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      nop_sel_q <= 1'b1;
      chk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      nop_sel_q <= nop_sel_d;
      chk_q     <= chk_d;
    end
  end

  assign ld_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign ld_done  = done_q;
  assign ld_count = count_q;
  assign f_valid  = valid_q;
  assign f_fault  = fault_q;
  // The read register holds across idle/stall cycles, so f_data holds with it.
  assign f_data   = nop_sel_q ? NOP_WORD : rd_word_s[31:0];

endmodule

// File: tb/tb_imem_loadable.sv
// Directed self-checking bench for imem_loadable (DEPTH=64, ADDR_W=32).
// With IMEM_PARITY_EN defined, a parity-error scenario is added.
module tb_imem_loadable;

  logic        clk;
  logic        rst_n;
  logic        ld_start;
  logic        ld_valid;
  logic        ld_last;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic [6:0]  ld_count;
  logic        busy;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_stall;
  logic        f_valid;
  logic [31:0] f_data;
  logic        f_fault;
`ifdef IMEM_PARITY_EN
  logic        f_perr;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_mem [64];

  imem_loadable #(.DEPTH(64), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_last  (ld_last),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_count (ld_count),
    .busy     (busy),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_stall  (f_stall),
    .f_valid  (f_valid),
    .f_data   (f_data),
    .f_fault  (f_fault)
`ifdef IMEM_PARITY_EN
    ,
    .f_perr   (f_perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'h0;
    f_req = 1'b0; f_addr = 32'h0; f_stall = 1'b0;
    #12;
    total_cnt++; if (f_valid !== 1'b0) $display("FAIL reset_f_valid got %b exp 0", f_valid); else pass_cnt++;
    total_cnt++; if (f_data !== 32'h0) $display("FAIL reset_f_data got %h exp 00000000", f_data); else pass_cnt++;
    total_cnt++; if (f_fault !== 1'b0) $display("FAIL reset_f_fault got %b exp 0", f_fault); else pass_cnt++;
    total_cnt++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready got %b exp 0", ld_ready); else pass_cnt++;
    total_cnt++; if (ld_done !== 1'b0) $display("FAIL reset_ld_done got %b exp 0", ld_done); else pass_cnt++;
    total_cnt++; if (ld_count !== 7'd0) $display("FAIL reset_ld_count got %0d exp 0", ld_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    f_req = 1'b1;
    tick();
    tick();
    total_cnt++; if (f_valid !== 1'b0) $display("FAIL idle_fetch_ignored got %b exp 0", f_valid); else pass_cnt++;
    f_req = 1'b0;
  endtask

  task automatic test_load_fetch();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    total_cnt++; if (busy !== 1'b1 || ld_ready !== 1'b1) $display("FAIL load_entry busy=%b ready=%b exp 1 1", busy, ld_ready); else pass_cnt++;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) begin
        ld_valid = 1'b0;
        tick();
        total_cnt++; if (ld_count !== 7'd10) $display("FAIL load_bubble_count got %0d exp 10", ld_count); else pass_cnt++;
      end
      exp_mem[i] = 32'hC0DE_0000 | 32'(i);
      ld_valid = 1'b1;
      ld_data  = exp_mem[i];
      ld_last  = (i == 29);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    total_cnt++; if (ld_done !== 1'b1) $display("FAIL load30_done got %b exp 1", ld_done); else pass_cnt++;
    total_cnt++; if (ld_count !== 7'd30) $display("FAIL load30_count got %0d exp 30", ld_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || ld_ready !== 1'b0) $display("FAIL load30_ready_state busy=%b ready=%b exp 0 0", busy, ld_ready); else pass_cnt++;
    f_req = 1'b1; f_addr = 32'h08;
    tick();
    f_req = 1'b0;
    total_cnt++; if (ld_done !== 1'b0) $display("FAIL done_pulse_width got %b exp 0", ld_done); else pass_cnt++;
    total_cnt++; if (f_valid !== 1'b1 || f_fault !== 1'b0) $display("FAIL fetch08_flags v=%b f=%b exp 1 0", f_valid, f_fault); else pass_cnt++;
    total_cnt++; if (f_data !== exp_mem[2]) $display("FAIL fetch08_data got %h exp %h", f_data, exp_mem[2]); else pass_cnt++;
    tick();
    total_cnt++; if (f_valid !== 1'b0 || f_data !== exp_mem[2]) $display("FAIL idle_hold v=%b d=%h exp 0 %h", f_valid, f_data, exp_mem[2]); else pass_cnt++;
  endtask

  task automatic test_faults();
    logic [31:0] addrs [4];
    logic        flt   [4];
    addrs[0] = 32'h06;   flt[0] = 1'b1;
    addrs[1] = 32'h78;   flt[1] = 1'b1;
    addrs[2] = 32'h1000; flt[2] = 1'b1;
    addrs[3] = 32'h74;   flt[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f_req = 1'b1; f_addr = addrs[i];
      tick();
      f_req = 1'b0;
      total_cnt++; if (f_valid !== 1'b1 || f_fault !== flt[i]) $display("FAIL fault_flag addr=%h v=%b f=%b exp 1 %b", addrs[i], f_valid, f_fault, flt[i]); else pass_cnt++;
      total_cnt++; if (f_data !== (flt[i] ? 32'h0 : exp_mem[29])) $display("FAIL fault_data addr=%h got %h", addrs[i], f_data); else pass_cnt++;
      tick();
      total_cnt++; if (f_fault !== 1'b0) $display("FAIL fault_clear addr=%h got %b exp 0", addrs[i], f_fault); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    f_req = 1'b1; f_addr = 32'h04;
    tick();
    f_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_addr = 32'h10 + 32'(4 * i);
      tick();
      total_cnt++; if (f_valid !== 1'b1 || f_data !== exp_mem[1] || f_fault !== 1'b0) $display("FAIL stall_hold cyc=%0d v=%b d=%h exp 1 %h", i, f_valid, f_data, exp_mem[1]); else pass_cnt++;
    end
    f_stall = 1'b0; f_addr = 32'h0C;
    tick();
    f_req = 1'b0;
    total_cnt++; if (f_valid !== 1'b1 || f_data !== exp_mem[3]) $display("FAIL stall_release v=%b d=%h exp 1 %h", f_valid, f_data, exp_mem[3]); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    f_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_addr = 32'(i * 8);
      tick();
      total_cnt++; if (f_valid !== 1'b1 || f_fault !== 1'b0 || f_data !== exp_mem[i * 2]) $display("FAIL b2b idx=%0d d=%h exp %h", i * 2, f_data, exp_mem[i * 2]); else pass_cnt++;
    end
    f_addr = 32'h7C;
    tick();
    f_req = 1'b0;
    total_cnt++; if (f_fault !== 1'b1 || f_data !== 32'h0) $display("FAIL b2b_fault f=%b d=%h exp 1 0", f_fault, f_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_forced_end();
    int gated_bad = 0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    f_req = 1'b1; f_addr = 32'h0;
    for (int i = 0; i < 64; i++) begin
      exp_mem[i] = 32'h5A00_0000 | 32'(i * 3);
      ld_valid = 1'b1; ld_last = 1'b0; ld_data = exp_mem[i];
      if (i == 63) begin
        total_cnt++; if (busy !== 1'b1) $display("FAIL forced_busy_before_last got %b exp 1", busy); else pass_cnt++;
      end
      tick();
      if (f_valid !== 1'b0) gated_bad++;
    end
    ld_valid = 1'b0; f_req = 1'b0;
    total_cnt++; if (gated_bad !== 0) $display("FAIL load_fetch_gating got %0d valid cycles exp 0", gated_bad); else pass_cnt++;
    total_cnt++; if (ld_done !== 1'b1 || busy !== 1'b0) $display("FAIL forced_end done=%b busy=%b exp 1 0", ld_done, busy); else pass_cnt++;
    total_cnt++; if (ld_count !== 7'd64) $display("FAIL forced_count got %0d exp 64", ld_count); else pass_cnt++;
    f_req = 1'b1; f_addr = 32'hFC;
    tick();
    total_cnt++; if (f_fault !== 1'b0 || f_data !== exp_mem[63]) $display("FAIL fetch_last f=%b d=%h exp 0 %h", f_fault, f_data, exp_mem[63]); else pass_cnt++;
    f_addr = 32'h100;
    tick();
    f_req = 1'b0;
    total_cnt++; if (f_fault !== 1'b1 || f_data !== 32'h0) $display("FAIL fetch_past_end f=%b d=%h exp 1 0", f_fault, f_data); else pass_cnt++;
  endtask

  task automatic test_reload();
    f_req = 1'b1; f_addr = 32'h0;
    tick();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0; f_req = 1'b0;
    total_cnt++; if (busy !== 1'b1 || ld_ready !== 1'b1) $display("FAIL reload_state busy=%b ready=%b exp 1 1", busy, ld_ready); else pass_cnt++;
    total_cnt++; if (f_valid !== 1'b0) $display("FAIL reload_drop_fetch got %b exp 0", f_valid); else pass_cnt++;
    total_cnt++; if (ld_count !== 7'd0) $display("FAIL reload_count got %0d exp 0", ld_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = 32'hDEAD_0000 | 32'(i);
      tick();
    end
    ld_valid = 1'b0;
    total_cnt++; if (ld_count !== 7'd5) $display("FAIL midload_count got %0d exp 5", ld_count); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0 || ld_ready !== 1'b0 || ld_done !== 1'b0) $display("FAIL midreset_ctrl busy=%b ready=%b done=%b exp 0 0 0", busy, ld_ready, ld_done); else pass_cnt++;
    total_cnt++; if (ld_count !== 7'd0) $display("FAIL midreset_count got %0d exp 0", ld_count); else pass_cnt++;
    total_cnt++; if (f_valid !== 1'b0 || f_fault !== 1'b0 || f_data !== 32'h0) $display("FAIL midreset_fetch v=%b f=%b d=%h exp 0 0 0", f_valid, f_fault, f_data); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL post_reset_idle busy=%b exp 0", busy); else pass_cnt++;
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'h2008_0020;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    dut.u_array.mem_q[0][0] = ~dut.u_array.mem_q[0][0];
    f_req = 1'b1; f_addr = 32'h0;
    tick();
    f_req = 1'b0;
    total_cnt++; if (f_perr !== 1'b1 || f_fault !== 1'b0) $display("FAIL parity_flag perr=%b f=%b exp 1 0", f_perr, f_fault); else pass_cnt++;
    total_cnt++; if (f_data !== 32'h2008_0021) $display("FAIL parity_data got %h exp 20080021", f_data); else pass_cnt++;
    tick();
    total_cnt++; if (f_perr !== 1'b0) $display("FAIL parity_clear got %b exp 0", f_perr); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_load_fetch();
    test_faults();
    test_stall();
    test_back_to_back();
    test_forced_end();
    test_reload();
    test_reset_mid_load();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
